// File: rtl/fir_ctrl_fsm_mc.sv
// Control FSM for the multi-channel decimating FIR: ADC intake, delay-line shift, MAC sequencing, DAC handoff.
// Latency: valid in IDLE @0 -> ready @1, shift @2, first MAC @3, last MAC @NTAPS+2, dac_conv_req @NTAPS+3.
// Backpressure: ADC valid waits in IDLE until taken; dac_conv_req holds in DAC_REQ until dac_conv_ack.
module fir_ctrl_fsm_mc #(
    parameter int NTAPS = 32,
    parameter int NCH   = 1,
    parameter int DECIM = 1,
    localparam int AW = $clog2(NTAPS),
    localparam int CW = ($clog2(NCH) > 0) ? $clog2(NCH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adc_conv_valid,
    output logic          adc_conv_ready,
    output logic [CW-1:0] ch_sel,
    output logic [AW-1:0] line_addr,
    output logic [AW-1:0] rom_addr,
    output logic          sample_shift,
    output logic          mac_init,
    output logic          mac_en,
    output logic          dac_conv_req,
    input  logic          dac_conv_ack,
    output logic          busy
);

    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [AW-1:0] TAP_LAST = AW'(NTAPS - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);
    localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET      = 3'd1,
        SHIFT    = 3'd2,
        MAC_INIT = 3'd3,
        MAC      = 3'd4,
        DAC_REQ  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] tap_cnt_q, tap_cnt_d;
    logic [CW-1:0] ch_cnt_q, ch_cnt_d;
    logic [DW-1:0] dec_cnt_q, dec_cnt_d;

    logic          ch_wrap;
    logic [CW-1:0] ch_next;

    // Channel advance shared by the non-filtering SHIFT exit and the DAC handoff.
    assign ch_wrap = (ch_cnt_q == CH_LAST);
    assign ch_next = ch_wrap ? '0 : ch_cnt_q + CW'(1);

    // State and counter registers; reset returns everything to IDLE with counters cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tap_cnt_q <= '0;
            ch_cnt_q  <= '0;
            dec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tap_cnt_q <= tap_cnt_d;
            ch_cnt_q  <= ch_cnt_d;
            dec_cnt_q <= dec_cnt_d;
        end
    end

    // Next-state, counter updates and Moore output decode from the registered state.
    always_comb begin
        state_d        = state_q;
        tap_cnt_d      = tap_cnt_q;
        ch_cnt_d       = ch_cnt_q;
        dec_cnt_d      = dec_cnt_q;
        adc_conv_ready = 1'b0;
        ch_sel         = '0;
        line_addr      = '0;
        rom_addr       = '0;
        sample_shift   = 1'b0;
        mac_init       = 1'b0;
        mac_en         = 1'b0;
        dac_conv_req   = 1'b0;
        busy           = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (adc_conv_valid) state_d = GET;
            end
            GET: begin
                adc_conv_ready = 1'b1;
                ch_sel         = ch_cnt_q;
                state_d        = SHIFT;
            end
            SHIFT: begin
                sample_shift = 1'b1;
                ch_sel       = ch_cnt_q;
                if (dec_cnt_q == DEC_LAST) begin
                    state_d = MAC_INIT;
                end else begin
                    // Decimated sample: only stored; move to the next channel slot.
                    ch_cnt_d = ch_next;
                    if (ch_wrap) dec_cnt_d = dec_cnt_q + DW'(1);
                    state_d = IDLE;
                end
            end
            MAC_INIT: begin
                mac_init  = 1'b1;
                mac_en    = 1'b1;
                ch_sel    = ch_cnt_q;
                rom_addr  = tap_cnt_q;
                line_addr = TAP_LAST - tap_cnt_q;
                tap_cnt_d = tap_cnt_q + AW'(1);
                state_d   = MAC;
            end
            MAC: begin
                mac_en    = 1'b1;
                ch_sel    = ch_cnt_q;
                rom_addr  = tap_cnt_q;
                line_addr = TAP_LAST - tap_cnt_q;
                if (tap_cnt_q == TAP_LAST) begin
                    tap_cnt_d = '0;
                    state_d   = DAC_REQ;
                end else begin
                    tap_cnt_d = tap_cnt_q + AW'(1);
                end
            end
            DAC_REQ: begin
                dac_conv_req = 1'b1;
                ch_sel       = ch_cnt_q;
                if (dac_conv_ack) begin
                    ch_cnt_d = ch_next;
                    // Last channel of the frame handed off: restart the decimation phase.
                    if (ch_wrap) dec_cnt_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                tap_cnt_d = '0;
                ch_cnt_d  = '0;
                dec_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_ctrl_fsm_mc.sv
// Bench for fir_ctrl_fsm_mc: a 32-tap single-channel instance driven from a cycle table,
// and a 4-tap two-channel decimate-by-3 instance checked against a scoreboard.
module tb_fir_ctrl_fsm_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A: NTAPS=32, NCH=1, DECIM=1
    logic       a_valid, a_ready, a_shift, a_init, a_en, a_req, a_ack, a_busy;
    logic [0:0] a_ch_sel;
    logic [4:0] a_line, a_rom;

    // Instance B: NTAPS=4, NCH=2, DECIM=3
    logic       b_valid, b_ready, b_shift, b_init, b_en, b_req, b_ack, b_busy;
    logic [0:0] b_ch_sel;
    logic [1:0] b_line, b_rom;

    fir_ctrl_fsm_mc #(.NTAPS(32), .NCH(1), .DECIM(1)) dut_a (
        .clk(clk), .reset(reset),
        .adc_conv_valid(a_valid), .adc_conv_ready(a_ready),
        .ch_sel(a_ch_sel), .line_addr(a_line), .rom_addr(a_rom),
        .sample_shift(a_shift), .mac_init(a_init), .mac_en(a_en),
        .dac_conv_req(a_req), .dac_conv_ack(a_ack), .busy(a_busy)
    );

    fir_ctrl_fsm_mc #(.NTAPS(4), .NCH(2), .DECIM(3)) dut_b (
        .clk(clk), .reset(reset),
        .adc_conv_valid(b_valid), .adc_conv_ready(b_ready),
        .ch_sel(b_ch_sel), .line_addr(b_line), .rom_addr(b_rom),
        .sample_shift(b_shift), .mac_init(b_init), .mac_en(b_en),
        .dac_conv_req(b_req), .dac_conv_ack(b_ack), .busy(b_busy)
    );

    logic [16:0] a_obs;
    logic [10:0] b_obs;
    assign a_obs = {a_ch_sel, a_ready, a_shift, a_init, a_en, a_req, a_busy, a_line, a_rom};
    assign b_obs = {b_ch_sel, b_ready, b_shift, b_init, b_en, b_req, b_busy, b_line, b_rom};

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        valid;
        logic        ack;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[48];

    function automatic logic [16:0] mk(input logic ch, input logic rdy, input logic sh,
                                       input logic ini, input logic en, input logic rq,
                                       input logic bsy, input int line, input int rom);
        logic [4:0] l5;
        logic [4:0] r5;
        l5 = 5'(line);
        r5 = 5'(rom);
        return {ch, rdy, sh, ini, en, rq, bsy, l5, r5};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sh_q[$];
        int rq_q[$];
        int gap_q[$];
        int dly_q[$];
        int nrdy, nsh, ninit, nen, nacc, wcnt, last_rdy, done, k;

        reset   = 1'b1;
        a_valid = 1'b0;
        a_ack   = 1'b0;
        b_valid = 1'b0;
        b_ack   = 1'b0;
        step();
        step();
        chk("reset_a", a_obs, 0);
        chk("reset_b", b_obs, 0);
        reset = 1'b0;
        step();
        chk("idle_a", a_obs, 0);
        chk("idle_b", b_obs, 0);

        // Cycle table for one filtered frame on A: valid @0, 11-cycle DAC stall, ack @46.
        // Spurious acks are applied in IDLE (@0) and mid-MAC (@10).
        for (int c = 0; c < 48; c++) begin
            logic en;
            en = (c >= 3) && (c <= 34);
            tbl[c].valid = (c == 0);
            tbl[c].ack   = (c == 0) || (c == 10) || (c == 46);
            tbl[c].exp   = mk(1'b0, c == 1, c == 2, c == 3, en,
                              (c >= 35) && (c <= 46), (c >= 1) && (c <= 46),
                              en ? 31 - (c - 3) : 0, en ? c - 3 : 0);
        end

        for (int c = 0; c < 48; c++) begin
            chk($sformatf("frame_a_cyc%0d", c), a_obs, tbl[c].exp);
            a_valid = tbl[c].valid;
            a_ack   = tbl[c].ack;
            step();
        end
        a_valid = 1'b0;
        a_ack   = 1'b0;
        chk("frame_a_back_idle", a_obs, 0);

        // Reset in MAC at tap 10, then a fresh sample must restart at tap 0 on ch 0.
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("rst_at_tap10", a_obs, mk(1'b0, 0, 0, 0, 1, 0, 1, 21, 10));
        reset = 1'b1;
        step();
        chk("rst_outputs_zero", a_obs, 0);
        reset   = 1'b0;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("rst_restart_get", a_obs, mk(1'b0, 1, 0, 0, 0, 0, 1, 0, 0));
        step();
        chk("rst_restart_shift", a_obs, mk(1'b0, 0, 1, 0, 0, 0, 1, 0, 0));
        step();
        chk("rst_restart_init", a_obs, mk(1'b0, 0, 0, 1, 1, 0, 1, 31, 0));
        k = 0;
        while (k < 60 && !a_req) begin
            step();
            k++;
        end
        chk("rst_req_latency", k, 32);
        a_ack = 1'b1;
        step();
        a_ack = 1'b0;
        chk("rst_final_idle", a_obs, 0);

        // Instance B: six back-to-back samples with valid held high; scoreboard queues
        // hold the expected shift channels, req channels and inter-ready gaps.
        for (int i = 0; i < 6; i++) sh_q.push_back(i % 2);
        rq_q.push_back(0);
        rq_q.push_back(1);
        for (int i = 0; i < 4; i++) gap_q.push_back(3);
        gap_q.push_back(8);
        dly_q.push_back(0);
        dly_q.push_back(2);

        nrdy = 0; nsh = 0; ninit = 0; nen = 0; nacc = 0;
        wcnt = -1; last_rdy = 0; done = 0;
        b_valid = 1'b1;
        for (int cyc = 0; cyc < 300 && done == 0; cyc++) begin
            if (b_ready) begin
                if (nrdy > 0 && gap_q.size() > 0)
                    chk($sformatf("b_gap_ready%0d", nrdy + 1), cyc - last_rdy, gap_q.pop_front());
                last_rdy = cyc;
                nrdy++;
            end
            if (b_shift) begin
                if (sh_q.size() > 0)
                    chk($sformatf("b_shift_ch%0d", nsh), b_ch_sel, sh_q.pop_front());
                nsh++;
            end
            if (b_init) ninit++;
            if (b_en) nen++;
            if (b_req) begin
                if (wcnt < 0) wcnt = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
                if (wcnt == 0) begin
                    b_ack = 1'b1;
                    if (rq_q.size() > 0)
                        chk($sformatf("b_req_ch%0d", nacc), b_ch_sel, rq_q.pop_front());
                    nacc++;
                    wcnt = -1;
                end else begin
                    b_ack = 1'b0;
                    wcnt--;
                end
            end else begin
                b_ack = b_en;
            end
            b_valid = (nrdy < 6);
            if (nrdy == 6 && nacc == 2 && !b_busy) done = 1;
            step();
        end
        b_valid = 1'b0;
        b_ack   = 1'b0;
        chk("b_finished_in_budget", done, 1);
        chk("b_ready_count", nrdy, 6);
        chk("b_shift_count", nsh, 6);
        chk("b_mac_init_count", ninit, 2);
        chk("b_mac_en_count", nen, 8);
        chk("b_req_accept_count", nacc, 2);
        chk("b_scoreboard_left", sh_q.size() + rq_q.size() + gap_q.size(), 0);
        step();
        chk("b_final_idle", b_obs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
